// File: rtl/if_stage.sv
// if_stage: PC owner and instruction fetch with a small buffering FIFO toward decode
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        id_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, req_pc_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q [DEPTH];
  logic          accept, push, pop;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = cnt_q != '0;
  assign inst_o       = inst_valid_o ? inst_mem_q[rd_q] : NOP_INST;
  assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_q] : 32'h0;
  assign accept       = imem_req_o & imem_ready_i;
  assign push         = state_q == WAIT && imem_rvalid_i && !redirect_valid_i;
  assign pop          = inst_valid_o && id_ready_i && !redirect_valid_i;
  // Request issue, next PC, next state and FIFO bookkeeping; redirect overrides all
  always_comb begin
    imem_req_o = !rst && !redirect_valid_i &&
                 ((state_q == FETCH && cnt_q < CW'(DEPTH)) ||
                  (state_q == WAIT && imem_rvalid_i && cnt_q < CW'(DEPTH - 1)));
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    if (redirect_valid_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      state_d = (state_q != FETCH && !imem_rvalid_i) ? DROP : FETCH;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      pc_d    = accept ? pc_q + 32'd4 : pc_q;
      state_d = accept ? WAIT : (state_q != FETCH && imem_rvalid_i) ? FETCH : state_q;
    end
  end
  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  // Remember the PC of the outstanding request and store returned words with it
  always_ff @(posedge clk) begin
    if (accept) req_pc_q <= pc_q;
    if (push) begin
      inst_mem_q[wr_q] <= imem_rdata_i;
      pc_mem_q[wr_q]   <= req_pc_q;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with a scoreboard-checked decode interface
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam logic [31:0] NOP    = 32'h0340_0000;
  localparam logic [31:0] KEY    = 32'h5A5A_A5A5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_ready, imem_rvalid, redirect_valid, inst_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  int npass = 0, ntot = 0, cyc = 0, lat = 1;
  bit mon_en = 1'b0;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} exp_t;
  typedef struct {logic [31:0] a; int due;} rsp_t;
  exp_t sbq[$];
  rsp_t mq[$];

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc), .id_ready_i(id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", n, act, exp);
  endtask

  function automatic void sbp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sbq.push_back('{base + 32'(4 * i), (base + 32'(4 * i)) ^ KEY});
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) tick();
    sbq.delete();
    rst = 1'b0;
  endtask

  // memory model: record acceptances, answer in order lat cycles later
  initial forever begin
    @(negedge clk);
    if (imem_req && imem_ready) mq.push_back('{imem_addr, cyc + lat});
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_rvalid = 1'b0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].a ^ KEY;
        void'(mq.pop_front());
      end
    end
  end

  // monitor: every consumed head must match the next expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (inst_valid) begin
          if (id_ready) begin
            if (sbq.size() == 0) begin
              ntot++;
              $display("FAIL sb_unexpected: got pc %h, expected no entry", inst_pc);
            end else begin
              e = sbq.pop_front();
              chk("sb_pc", inst_pc, e.pc);
              chk("sb_inst", inst, e.ins);
            end
          end
        end else begin
          chk("idle_inst", inst, NOP);
          chk("idle_pc", inst_pc, 32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    imem_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 0);
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    // steady state, zero-wait memory
    id_ready = 1'b1; imem_ready = 1'b1; lat = 1;
    sbp(RST_PC, 20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("s1_req", 32'(imem_req), 1);
      chk("s1_addr", imem_addr, RST_PC + 32'(4 * k));
      chk("s1_valid", 32'(inst_valid), 32'(k >= 2));
      if (k >= 2) chk("s1_pc", inst_pc, RST_PC + 32'(4 * (k - 2)));
      tick();
    end
    // decode stalled: FIFO fills, then drains in order
    do_reset(2);
    lat = 1; imem_ready = 1'b1; id_ready = 1'b0;
    sbp(RST_PC, 16);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        chk("s2_req", 32'(imem_req), 1);
        chk("s2_addr", imem_addr, RST_PC + 32'(4 * k));
      end else begin
        chk("s2_noreq", 32'(imem_req), 0);
        chk("s2_hold_addr", imem_addr, RST_PC + 32'h10);
      end
      if (k >= 5) chk("s2_head", inst_pc, RST_PC);
      tick();
    end
    id_ready = 1'b1;
    for (int k = 8; k < 16; k++) begin
      @(negedge clk);
      if (k == 8) chk("s2_full_req", 32'(imem_req), 0);
      if (k == 9) begin
        chk("s2_resume_req", 32'(imem_req), 1);
        chk("s2_resume_addr", imem_addr, RST_PC + 32'h10);
      end
      tick();
    end
    // memory not ready for three cycles
    do_reset(2);
    lat = 1; imem_ready = 1'b0; id_ready = 1'b1;
    sbp(RST_PC, 16);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s3_req", 32'(imem_req), 1);
      chk("s3_addr", imem_addr, RST_PC);
      tick();
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk("s3_acc_addr", imem_addr, RST_PC);
    tick();
    @(negedge clk);
    chk("s3_next_addr", imem_addr, RST_PC + 32'h4);
    tick();
    @(negedge clk);
    chk("s3_valid", 32'(inst_valid), 1);
    repeat (3) tick();
    // redirect with a request outstanding
    do_reset(2);
    lat = 2; imem_ready = 1'b1; id_ready = 1'b1;
    sbp(RST_PC, 16);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) chk("s4_wait_req", 32'(imem_req), 0);
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h1C00_0102;
    @(negedge clk);
    chk("s4_redir_req", 32'(imem_req), 0);
    chk("s4_redir_head", inst_pc, RST_PC + 32'h4);
    tick();
    redirect_valid = 1'b0;
    sbq.delete();
    sbp(32'h1C00_0100, 8);
    @(negedge clk);
    chk("s4_drop_req", 32'(imem_req), 0);
    chk("s4_drop_valid", 32'(inst_valid), 0);
    tick();
    @(negedge clk);
    chk("s4_new_req", 32'(imem_req), 1);
    chk("s4_new_addr", imem_addr, 32'h1C00_0100);
    tick();
    @(negedge clk);
    chk("s4_empty1", 32'(inst_valid), 0);
    tick();
    @(negedge clk);
    chk("s4_empty2", 32'(inst_valid), 0);
    tick();
    @(negedge clk);
    chk("s4_first_pc", inst_pc, 32'h1C00_0100);
    repeat (4) tick();
    // redirect coinciding with a response and a pop
    do_reset(2);
    lat = 1; imem_ready = 1'b1; id_ready = 1'b1;
    sbp(RST_PC, 16);
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h1C00_0203;
    @(negedge clk);
    chk("s5_redir_req", 32'(imem_req), 0);
    chk("s5_redir_head", inst_pc, RST_PC);
    tick();
    redirect_valid = 1'b0;
    sbq.delete();
    sbp(32'h1C00_0200, 8);
    @(negedge clk);
    chk("s5_empty", 32'(inst_valid), 0);
    chk("s5_req", 32'(imem_req), 1);
    chk("s5_addr", imem_addr, 32'h1C00_0200);
    tick();
    @(negedge clk);
    chk("s5_empty2", 32'(inst_valid), 0);
    chk("s5_addr2", imem_addr, 32'h1C00_0204);
    tick();
    @(negedge clk);
    chk("s5_first_pc", inst_pc, 32'h1C00_0200);
    repeat (3) tick();
    // reset while waiting with two entries buffered; late response must be ignored
    do_reset(2);
    lat = 3; imem_ready = 1'b1; id_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("s6_req", 32'(imem_req), 1);
        chk("s6_addr", imem_addr, RST_PC + 32'h8);
        chk("s6_head", inst_pc, RST_PC);
      end
      tick();
    end
    rst = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    chk("s6_rst_req", 32'(imem_req), 0);
    tick();
    rst = 1'b0;
    sbq.delete();
    sbp(RST_PC, 8);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        imem_ready = 1'b1;
        id_ready = 1'b1;
      end
      @(negedge clk);
      chk("s6_post_valid", 32'(inst_valid), 0);
      chk("s6_post_req", 32'(imem_req), 1);
      chk("s6_post_addr", imem_addr, RST_PC);
      tick();
    end
    repeat (3) tick();
    @(negedge clk);
    chk("s6_first_valid", 32'(inst_valid), 1);
    chk("s6_first_pc", inst_pc, RST_PC);
    tick();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
